// File: rtl/mem_stage.sv
// MIPS memory stage: byte/half/word loads and stores against an internal
// synchronous data memory, MEM/WB register, and a read-only debug port.
module mem_stage #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_ADDR = 7
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic [NB_DATA-1:0] alu_result_i,
    input  logic [NB_DATA-1:0] data_rb_i,
    input  logic [NB_REG-1:0]  writeReg_i,
    input  logic               memRead_i,
    input  logic               memWrite_i,
    input  logic               regWrite_i,
    input  logic               memToReg_i,
    input  logic [1:0]         size_i,
    input  logic               unsigned_i,
    input  logic [NB_ADDR-1:0] debug_addr_i,
    output logic [NB_DATA-1:0] debug_data_o,
    output logic [NB_DATA-1:0] wb_data_o,
    output logic [NB_REG-1:0]  writeReg_o,
    output logic               regWrite_o,
    output logic               misaligned_o
);

    localparam int DEPTH = 2 ** NB_ADDR;

    logic [NB_DATA-1:0] mem [DEPTH];

    logic [NB_ADDR-1:0] word_idx;
    logic [1:0]         lane;
    logic               is_word;
    logic               is_half;
    logic               misaligned;
    logic               do_store;
    logic               do_load;
    logic [3:0]         byte_en;
    logic [NB_DATA-1:0] store_data;

    assign word_idx = alu_result_i[NB_ADDR+1:2];
    assign lane     = alu_result_i[1:0];

    // size 10 is treated the same as a full word
    always_comb begin
        is_word    = size_i[1];
        is_half    = (size_i == 2'b01);
        misaligned = (memRead_i | memWrite_i) &
                     ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
        do_store   = enable_i & memWrite_i & ~misaligned;
        do_load    = memRead_i & ~memWrite_i & ~misaligned;

        byte_en    = 4'b0000;
        store_data = data_rb_i;
        if (is_word) begin
            byte_en    = 4'b1111;
            store_data = data_rb_i;
        end else if (is_half) begin
            byte_en    = lane[1] ? 4'b1100 : 4'b0011;
            store_data = {(NB_DATA/16){data_rb_i[15:0]}};
        end else begin
            byte_en    = 4'b0001 << lane;
            store_data = {(NB_DATA/8){data_rb_i[7:0]}};
        end
    end

    // Memory is deliberately outside reset so a store coinciding with reset still lands.
    always_ff @(posedge clock_i) begin
        if (do_store) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[word_idx][8*k +: 8] <= store_data[8*k +: 8];
                end
            end
        end
    end

    logic [NB_DATA-1:0] read_word_q;
    logic               load_valid_q;
    logic [1:0]         lane_q;
    logic [1:0]         size_q;
    logic               unsigned_q;
    logic               mem_to_reg_q;
    logic [NB_DATA-1:0] alu_q;
    logic [NB_REG-1:0]  write_reg_q;
    logic               reg_write_q;
    logic               sticky_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            read_word_q  <= '0;
            load_valid_q <= 1'b0;
            lane_q       <= 2'b00;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_q        <= '0;
            write_reg_q  <= '0;
            reg_write_q  <= 1'b0;
            sticky_q     <= 1'b0;
        end else if (enable_i) begin
            read_word_q  <= mem[word_idx];
            load_valid_q <= do_load;
            lane_q       <= lane;
            size_q       <= size_i;
            unsigned_q   <= unsigned_i;
            mem_to_reg_q <= memToReg_i;
            alu_q        <= alu_result_i;
            write_reg_q  <= writeReg_i;
            reg_write_q  <= regWrite_i & ~misaligned;
            if (misaligned) begin
                sticky_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            debug_data_o <= '0;
        end else begin
            debug_data_o <= mem[debug_addr_i];
        end
    end

    logic [7:0]         sel_byte;
    logic [15:0]        sel_half;
    logic [NB_DATA-1:0] load_data;

    always_comb begin
        sel_byte = read_word_q[{lane_q, 3'b000} +: 8];
        sel_half = lane_q[1] ? read_word_q[31:16] : read_word_q[15:0];
        if (size_q[1]) begin
            load_data = read_word_q;
        end else if (size_q[0]) begin
            load_data = unsigned_q ? {{(NB_DATA-16){1'b0}}, sel_half}
                                   : {{(NB_DATA-16){sel_half[15]}}, sel_half};
        end else begin
            load_data = unsigned_q ? {{(NB_DATA-8){1'b0}}, sel_byte}
                                   : {{(NB_DATA-8){sel_byte[7]}}, sel_byte};
        end
        if (!load_valid_q) begin
            load_data = '0;
        end
    end

    assign wb_data_o    = mem_to_reg_q ? load_data : alu_q;
    assign writeReg_o   = write_reg_q;
    assign regWrite_o   = reg_write_q;
    assign misaligned_o = sticky_q;

endmodule
